// File: rtl/alb_mw_seq.sv
// Multi-word sequencer for an 8-bit ALU slice: issues one word per cycle LSW first,
// chains slice carry, assembles the wide result and whole-operand flags.
module alb_mw_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [DATA_WIDTH*WORDS-1:0] op_a,
  input  logic [DATA_WIDTH*WORDS-1:0] op_b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_WIDTH*WORDS-1:0] result,
  output logic                        co,
  output logic                        vo,
  output logic                        no,
  output logic                        zo,
  output logic [DATA_WIDTH-1:0]       alu_a,
  output logic [DATA_WIDTH-1:0]       alu_b,
  output logic                        alu_ci,
  output logic [1:0]                  alu_i,
  input  logic [DATA_WIDTH-1:0]       alu_f,
  input  logic                        alu_co,
  input  logic                        alu_vo,
  input  logic                        alu_no,
  input  logic                        alu_zo
);

  localparam int W     = DATA_WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     result_q, result_d;
  logic             co_q, co_d, vo_q, vo_d, no_q, no_d, zo_q, zo_d;

  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     res_acc_q, res_acc_d;
  logic [1:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic             zo_acc_q, zo_acc_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    result_d  = result_q;
    co_d      = co_q;
    vo_d      = vo_q;
    no_d      = no_q;
    zo_d      = zo_q;
    a_d       = a_q;
    b_d       = b_q;
    res_acc_d = res_acc_q;
    op_d      = op_q;
    cin_d     = cin_q;
    zo_acc_d  = zo_acc_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_ci    = 1'b0;
    alu_i     = op_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          op_d     = op;
          cin_d    = cin;
          idx_d    = '0;
          zo_acc_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        alu_a = a_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        alu_b = b_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        // Carry for word k>0 comes straight from the ALU's previous-slice carry.
        if (op_q[0]) begin
          alu_ci = (idx_q == '0) ? cin_q : alu_co;
        end
        if (idx_q != '0) begin
          res_acc_d[(int'(idx_q)-1)*DATA_WIDTH +: DATA_WIDTH] = alu_f;
          zo_acc_d = zo_acc_q & alu_zo;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        result_d = res_acc_q;
        result_d[W-1 -: DATA_WIDTH] = alu_f;
        zo_d    = zo_acc_q & alu_zo;
        co_d    = alu_co;
        vo_d    = alu_vo;
        no_d    = alu_no;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      vo_q     <= 1'b0;
      no_q     <= 1'b0;
      zo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      co_q     <= co_d;
      vo_q     <= vo_d;
      no_q     <= no_d;
      zo_q     <= zo_d;
    end
  end

  // Operand latches and partial-result accumulators carry no reset.
  always_ff @(posedge clk) begin
    a_q       <= a_d;
    b_q       <= b_d;
    res_acc_q <= res_acc_d;
    op_q      <= op_d;
    cin_q     <= cin_d;
    zo_acc_q  <= zo_acc_d;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign co     = co_q;
  assign vo     = vo_q;
  assign no     = no_q;
  assign zo     = zo_q;

endmodule
